pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register map. Takes the output-enable, PWM-enable and duty-cycle registers and drives 16 registered output pins. Each pin is one of: forced low, static high, or a shared PWM waveform. An internal prescaler plus an 8-bit period counter set the PWM frequency, nominally ~3 kHz from a 10 MHz clk.

Parameters:
PRESCALE, 13, clk cycles per PWM step; legal range 1..65535; PWM period = PRESCALE*256 clk cycles (3328 cycles by default).
NUM_OUT, 16, number of output pins; fixed to 16 for this register map.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM select, pins 7..0
en_reg_pwm_15_8  input  8  PWM select, pins 15..8
pwm_duty_cycle  input  8  shared duty value, 0x00..0xFF
out  output  16  pin drive; out[i] corresponds to enable bit i

Behaviour:
- Reset values: out = 16'h0000, prescaler count = 0, step counter = 0, duty_active = 0x00.
- Inputs come from same-clk registers. No input synchronisers.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - step_tick = 1 on the cycle the prescaler equals PRESCALE-1.
  - With PRESCALE=1, step_tick is 1 every cycle.
- Step counter:
  - 8-bit, increments on step_tick, wraps 255 -> 0.
  - period_start = 1 on the cycle step_tick occurs while the counter is 255.
- PWM level, combinational from counter and duty_active:
  - duty_active == 0xFF -> pwm = 1 continuously.
  - Otherwise pwm = (counter < duty_active).
  - So 0x00 is continuously low and 0x80 is high for 128 of 256 steps.
- Per pin i, with e = en_out[i] and p = en_pwm[i]:
  - e=0 -> 0, regardless of p.
  - e=1, p=0 -> 1.
  - e=1, p=1 -> pwm.
- Latency: out is registered. out[i] in cycle t+1 reflects the enables, counter and duty_active sampled in cycle t.
- Enable changes take effect on the next clk edge. They are not aligned to period boundaries.
- Duty update: see Optional Feature. With the macro absent, duty_active tracks pwm_duty_cycle every cycle.
- Counter is free-running. It is not reset by register writes or by enable changes.
- All pins with PWM selected share one phase (all rise at counter 0).
- Reset asserted mid-period: out goes to 0 asynchronously and all counters clear. After release, counting restarts from 0.

Optional Feature:
Macro PWM_SYNC_UPDATE_EN.
- Defined:
  - duty_active is a shadow register loaded from pwm_duty_cycle only on the cycle period_start is 1.
  - A write mid-period leaves the current period unchanged. No glitch or runt pulse.
  - The first period after reset uses duty 0x00.
- Undefined:
  - duty_active = pwm_duty_cycle combinationally, and there is no shadow register.
  - A mid-period change affects the compare immediately.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_STEPS = 256
  - DUTY_W = 8
  - NUM_OUT = 16
  - DUTY_FULL = 8'hFF
  - PRESCALE_DEFAULT = 13
- One sub-module, pwm_timebase: prescaler plus step counter. Outputs are step counter[7:0], step_tick and period_start.
- The top level does the enable concatenation ({15_8, 7_0}), duty shadowing, compare and output register.

Test Plan:
- Reset: hold rst_n=0 with all enables 0xFF and duty 0x80 -> out=0x0000. Release -> counter starts at 0.
- Static drive: en_out=0xA5C3, en_pwm=0x0000 -> out=0xA5C3 one cycle later. Clear en_out -> out=0x0000 next cycle.
- PWM ratio: PRESCALE=1, en_out=en_pwm=0xFFFF, duty 0x80 -> each pin high exactly 128 of every 256 cycles. Repeat with PRESCALE=13 -> period 3328 cycles and high time 1664 cycles.
- Duty extremes (PRESCALE=1):
  - duty 0x00 -> out stays 0 for 1000 cycles.
  - duty 0xFF -> out stays 0xFFFF for 1000 cycles.
  - duty 0x01 -> a 1-cycle high pulse every 256 cycles.
- Mixed pins: en_out=0x00FF, en_pwm=0x0F0F, duty 0x40 -> pins 3..0 toggle at 25%, pins 7..4 are static 1, pins 15..8 are 0.
- Duty write mid-period with PWM_SYNC_UPDATE_EN, PRESCALE=1: change 0x20 -> 0xC0 at counter 100 -> the current period keeps its 32-cycle high time and the next period is high for 192 cycles. Without the macro, high time follows the new value immediately. Also assert rst_n mid-period -> out clears at once.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, types and compare helper for the PWM peripheral
// Purpose: common sizing for pwm_timebase and pwm_peripheral.
// Contents: PWM_STEPS, DUTY_W, NUM_OUT, DUTY_FULL, PRESCALE_DEFAULT,
//           duty_t / pin_vec_t, pwm_level().
package pwm_pkg;

  localparam int unsigned PWM_STEPS        = 256;
  localparam int unsigned DUTY_W           = 8;
  localparam int unsigned NUM_OUT          = 16;
  localparam logic [7:0]  DUTY_FULL        = 8'hFF;
  localparam int unsigned PRESCALE_DEFAULT = 13;

  typedef logic [DUTY_W-1:0]  duty_t;
  typedef logic [NUM_OUT-1:0] pin_vec_t;

  // 0xFF is treated as "always on" so full duty has no one-step low gap.
  function automatic logic pwm_level(input duty_t cnt, input duty_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and 8-bit step counter for the PWM period
// Purpose: divides clk by PRESCALE into step ticks and counts 256 steps per period.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   step_cnt_o       current step within the period (0..255)
//   step_tick_o      1 on the last prescaler cycle of each step
//   period_start_o   1 on the step tick that wraps the counter 255 -> 0
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] step_cnt_o,
  output logic              step_tick_o,
  output logic              period_start_o
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0]       presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              step_tick;

  assign step_tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = step_tick ? 16'd0 : presc_q + 16'd1;
    cnt_d   = step_tick ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step_cnt_o     = cnt_q;
  assign step_tick_o    = step_tick;
  assign period_start_o = step_tick && (cnt_q == 8'hFF);

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin output driver: forced low, static high or shared PWM
// Purpose: combines output/PWM enables with one shared PWM waveform into registered pins.
// Config macro: PWM_SYNC_UPDATE_EN - when defined, the duty value is shadowed and only
//   loaded at a period boundary; when undefined, the duty input drives the compare directly.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   en_reg_out_7_0 / en_reg_out_15_8   output enables, pins 7..0 / 15..8
//   en_reg_pwm_7_0 / en_reg_pwm_15_8   PWM selects, pins 7..0 / 15..8
//   pwm_duty_cycle                     shared duty value
//   out                                registered pin drive, out[i] <-> enable bit i
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0]  pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out
);

  pin_vec_t en_out;
  pin_vec_t en_pwm;
  duty_t    step_cnt;
  duty_t    duty_active;
  logic     period_start;
  logic     unused_step_tick;
  logic     pwm;
  pin_vec_t out_q, out_d;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .step_cnt_o     (step_cnt),
    .step_tick_o    (unused_step_tick),
    .period_start_o (period_start)
  );

`ifdef PWM_SYNC_UPDATE_EN
  // Shadow register: a mid-period write waits for the wrap so no runt pulse appears.
  duty_t duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (period_start) begin
      duty_d = pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_active = duty_q;
`else
  logic unused_period_start;

  assign duty_active         = pwm_duty_cycle;
  assign unused_period_start = period_start;
`endif

  assign pwm = pwm_level(step_cnt, duty_active);

  // Disabled pins are low; enabled pins are high unless PWM-selected.
  always_comb begin
    out_d = en_out & (~en_pwm | {NUM_OUT{pwm}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - self-checking bench for pwm_peripheral (PRESCALE 1 and 13)
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out1, out13;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out1)
  );

  pwm_peripheral #(.PRESCALE(13)) dut13 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out13)
  );

  // Reference model: time since reset release gives the PWM step directly.
  function automatic logic [15:0] ref_pins(input logic [15:0] eo, input logic [15:0] ep,
                                           input int unsigned d, input int unsigned step);
    logic [15:0] r;
    logic        lvl;
    lvl = (d == 255) ? 1'b1 : (step < d);
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])     r[i] = 1'b0;
      else if (!ep[i]) r[i] = 1'b1;
      else            r[i] = lvl;
    end
    return r;
  endfunction

  int unsigned mc;
  logic [7:0]  sh1, sh13;
  logic [15:0] exp1, exp13;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc    <= 0;
      sh1   <= 8'h00;
      sh13  <= 8'h00;
      exp1  <= 16'h0000;
      exp13 <= 16'h0000;
    end else begin
`ifdef PWM_SYNC_UPDATE_EN
      exp1  <= ref_pins({eo_hi, eo_lo}, {ep_hi, ep_lo}, sh1,  (mc / 1)  % 256);
      exp13 <= ref_pins({eo_hi, eo_lo}, {ep_hi, ep_lo}, sh13, (mc / 13) % 256);
      if ((mc + 1) % 256 == 0)        sh1  <= duty;
      if ((mc + 1) % (256 * 13) == 0) sh13 <= duty;
`else
      exp1  <= ref_pins({eo_hi, eo_lo}, {ep_hi, ep_lo}, duty, (mc / 1)  % 256);
      exp13 <= ref_pins({eo_hi, eo_lo}, {ep_hi, ep_lo}, duty, (mc / 13) % 256);
`endif
      mc <= mc + 1;
    end
  end

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic test_reset();
    logic [15:0] first_req;
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    repeat (3) @(negedge clk);
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL reset_out1 got=%h want=0000", out1); end
    total++; if (out13 !== 16'h0000) begin bad++; $display("FAIL reset_out13 got=%h want=0000", out13); end
    duty  = 8'h01;
    rst_n = 1'b1;
`ifdef PWM_SYNC_UPDATE_EN
    first_req = 16'h0000;
`else
    first_req = 16'hFFFF;
`endif
    @(negedge clk);
    total++; if (out1 !== first_req) begin bad++; $display("FAIL start_step0 got=%h want=%h", out1, first_req); end
    @(negedge clk);
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL start_step1 got=%h want=0000", out1); end
  endtask

  task automatic test_static();
    set_en(16'hA5C3, 16'h0000);
    @(negedge clk);
    total++; if (out1 !== 16'hA5C3) begin bad++; $display("FAIL static_on1 got=%h want=a5c3", out1); end
    total++; if (out13 !== 16'hA5C3) begin bad++; $display("FAIL static_on13 got=%h want=a5c3", out13); end
    set_en(16'h0000, 16'h0000);
    @(negedge clk);
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL static_off1 got=%h want=0000", out1); end
    total++; if (out13 !== 16'h0000) begin bad++; $display("FAIL static_off13 got=%h want=0000", out13); end
  endtask

  task automatic test_pwm_ratio();
    int h1 = 0, h13 = 0, mism = 0;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    repeat (3400) @(negedge clk);
    for (int i = 0; i < 3328; i++) begin
      @(negedge clk);
      h1  += int'(out1[0]);
      h13 += int'(out13[0]);
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (h1 !== 1664) begin bad++; $display("FAIL ratio_p1 high=%0d want=1664", h1); end
    total++; if (h13 !== 1664) begin bad++; $display("FAIL ratio_p13 high=%0d want=1664", h13); end
    total++; if (mism !== 0) begin bad++; $display("FAIL ratio_model mismatches=%0d want=0", mism); end
  endtask

  task automatic test_duty_extremes();
    int nz = 0, nf = 0, highs = 0, rises = 0, mism = 0;
    logic prev = 1'b0;
    duty = 8'h00;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out1 !== 16'h0000) nz++;
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL duty00 nonzero_cycles=%0d want=0", nz); end
    duty = 8'hFF;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out1 !== 16'hFFFF) nf++;
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (nf !== 0) begin bad++; $display("FAIL dutyff notfull_cycles=%0d want=0", nf); end
    duty = 8'h01;
    repeat (300) @(negedge clk);
    prev = out1[0];
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      highs += int'(out1[0]);
      if (out1[0] && !prev) rises++;
      prev = out1[0];
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (highs !== 2) begin bad++; $display("FAIL duty01 high=%0d want=2", highs); end
    total++; if (rises !== 2) begin bad++; $display("FAIL duty01 pulses=%0d want=2", rises); end
    total++; if (mism !== 0) begin bad++; $display("FAIL extremes_model mismatches=%0d want=0", mism); end
  endtask

  task automatic test_mixed();
    int on = 0, odd = 0, mism = 0;
    set_en(16'h00FF, 16'h0F0F);
    duty = 8'h40;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (out1[3:0] === 4'hF) on++;
      else if (out1[3:0] !== 4'h0) odd++;
      if (out1[15:4] !== 12'h00F) odd++;
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (on !== 64) begin bad++; $display("FAIL mixed_pwm_high=%0d want=64", on); end
    total++; if (odd !== 0) begin bad++; $display("FAIL mixed_static_bad=%0d want=0", odd); end
    total++; if (mism !== 0) begin bad++; $display("FAIL mixed_model mismatches=%0d want=0", mism); end
  endtask

  task automatic test_random();
    int mism = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(5) == 0) duty = 8'($urandom);
      @(negedge clk);
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (mism !== 0) begin bad++; $display("FAIL random_model mismatches=%0d want=0", mism); end
  endtask

  task automatic test_back_to_back_duty();
    int hi[3] = '{0, 0, 0};
    int want0, want1, mism = 0;
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 768; c++) begin
      if (c == 356) duty = 8'hC0;
      @(posedge clk);
      @(negedge clk);
      hi[c / 256] += int'(out1[0]);
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
`ifdef PWM_SYNC_UPDATE_EN
    want0 = 0;
    want1 = 32;
`else
    want0 = 32;
    want1 = 124;
`endif
    total++; if (hi[0] !== want0) begin bad++; $display("FAIL midwrite_p0 high=%0d want=%0d", hi[0], want0); end
    total++; if (hi[1] !== want1) begin bad++; $display("FAIL midwrite_p1 high=%0d want=%0d", hi[1], want1); end
    total++; if (hi[2] !== 192) begin bad++; $display("FAIL midwrite_p2 high=%0d want=192", hi[2]); end
    total++; if (mism !== 0) begin bad++; $display("FAIL midwrite_model mismatches=%0d want=0", mism); end
  endtask

  task automatic test_reset_mid_period();
    int mism = 0;
    set_en(16'hFFFF, 16'h00FF);
    duty = 8'h80;
    repeat (20) @(negedge clk);
    total++; if (out1[15:8] !== 8'hFF) begin bad++; $display("FAIL pre_reset_static got=%h want=ff", out1[15:8]); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL async_reset1 got=%h want=0000", out1); end
    total++; if (out13 !== 16'h0000) begin bad++; $display("FAIL async_reset13 got=%h want=0000", out13); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out1 !== exp1 || out13 !== exp13) mism++;
    end
    total++; if (mism !== 0) begin bad++; $display("FAIL restart_model mismatches=%0d want=0", mism); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm_ratio();
    test_duty_extremes();
    test_mixed();
    test_random();
    test_back_to_back_duty();
    test_reset_mid_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
